// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle for the shared execute ALU.
// The arbiter is the slave; requesters, ALU and consumer sit on the master side.
interface alu_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic [2:0]        alu_flags;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic [2:0]        flags_q;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_flags, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_result, flags_q
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_flags, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_result, flags_q
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one execute ALU between two requesters,
// with registered operands, tagged responses and the N/Z/V flag register.
module alu_arbiter #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    logic              last_served;
    logic              can_accept;
    logic              pick0;
    logic              pick1;
    logic              acc;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [OP_W-1:0]   sel_op;
    logic              nv_we;
    logic              z_we;
    logic [2:0]        fmask;

    assign can_accept = (state == IDLE) |
                        ((state == RESP) & bus.rsp_ready);

    // On a tie the requester not served last time wins.
    assign pick1 = bus.req1_valid &
                   (~bus.req0_valid | ~last_served);
    assign pick0 = bus.req0_valid & ~pick1;

    assign bus.req0_ready = can_accept & pick0;
    assign bus.req1_ready = can_accept & pick1;
    assign acc = can_accept & (pick0 | pick1);

    assign sel_a  = pick1 ? bus.req1_a  : bus.req0_a;
    assign sel_b  = pick1 ? bus.req1_b  : bus.req0_b;
    assign sel_op = pick1 ? bus.req1_op : bus.req0_op;

    always_comb begin
        nv_we = 1'b0;
        z_we  = 1'b0;
        unique case (1'b1)
            (bus.alu_op inside {4'd0, 4'd1}): begin
                nv_we = 1'b1;
                z_we  = 1'b1;
            end
            (bus.alu_op inside {4'd2, 4'd4, 4'd5, 4'd6}): begin
                z_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign fmask = {nv_we, z_we, nv_we};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_served    <= 1'b1;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_op     <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.flags_q    <= 3'b000;
        end else begin
            if (acc) begin
                bus.alu_a   <= sel_a;
                bus.alu_b   <= sel_b;
                bus.alu_op  <= sel_op;
                bus.rsp_id  <= pick1;
                last_served <= pick1;
            end
            unique case (state)
                IDLE: begin
                    if (acc) state <= EXEC;
                end
                EXEC: begin
                    bus.rsp_result <= bus.alu_result;
                    bus.flags_q    <= (bus.alu_flags & fmask) |
                                      (bus.flags_q & ~fmask);
                    bus.rsp_valid  <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= acc ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed cases then random traffic,
// with a small ALU model and an operation-level reference model.
module tb_alu_arbiter;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } req_t;

    typedef struct {
        logic        id;
        logic [15:0] res;
        logic [2:0]  fl;
        time         t;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_arbiter_if bus ();

    alu_arbiter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];
    logic glog[$];

    int   tests = 0;
    int   fails = 0;
    bit   m_out;
    bit   m_last;
    time  m_tacc;
    logic [2:0] m_flags;
    int   rmode;
    bit   gap_en;
    bit   seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(logic [15:0] a, logic [15:0] b,
                                          logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a & b);
            4'd6:    return a << b[3:0];
            4'd7:    return a >> b[3:0];
            4'd8:    return b;
            4'd9:    return a;
            4'd10:   return {a[15:8], b[7:0]};
            4'd11:   return {b[7:0], a[7:0]};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [2:0] alu_fl(logic [15:0] a, logic [15:0] b,
                                          logic [3:0] op);
        logic [15:0] r;
        logic v;
        r = alu_f(a, b, op);
        v = 1'b0;
        if (op == 4'd0) v = (a[15] == b[15]) && (r[15] != a[15]);
        if (op == 4'd1) v = (a[15] != b[15]) && (r[15] != a[15]);
        return {r[15], r == 16'h0000, v};
    endfunction

    // Which flag bits an opcode is allowed to write, {N,Z,V}.
    function automatic logic [2:0] wmask(logic [3:0] op);
        logic nv;
        logic z;
        nv = (op == 4'd0) || (op == 4'd1);
        z  = op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
        return {nv, z, nv};
    endfunction

    // External ALU stand-in.
    always_comb begin
        bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
        bus.alu_flags  = alu_fl(bus.alu_a, bus.alu_b, bus.alu_op);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Response monitor.
    initial begin
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    if (!seen) begin
                        chk("latency", 32'($time - sb[0].t), 32'd20);
                        seen = 1'b1;
                    end
                    chk("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
                    chk("rsp_result", 32'(bus.rsp_result), 32'(sb[0].res));
                    chk("flags_q", 32'(bus.flags_q), 32'(sb[0].fl));
                    if (bus.rsp_ready) begin
                        glog.push_back(bus.rsp_id);
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic push_op(bit who, logic [15:0] a, logic [15:0] b,
                           logic [3:0] op);
        req_t r;
        r.a  = a;
        r.b  = b;
        r.op = op;
        if (who) q1.push_back(r);
        else q0.push_back(r);
    endtask

    // One clock: check the handshake against the model, then drive.
    task automatic cycle();
        bit   can;
        bit   v0;
        bit   v1;
        bit   g;
        bit   e0;
        bit   e1;
        req_t r;
        exp_t e;
        @(negedge clk);
        can = !m_out || (bus.rsp_ready && ($time - m_tacc) >= 20);
        if (can) m_out = 1'b0;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        g  = (v0 && v1) ? !m_last : v1;
        e0 = can && v0 && !g;
        e1 = can && v1 && g;
        chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
        if (e0 || e1) begin
            r = e0 ? q0[0] : q1[0];
            m_flags = (alu_fl(r.a, r.b, r.op) & wmask(r.op)) |
                      (m_flags & ~wmask(r.op));
            e.id  = g;
            e.res = alu_f(r.a, r.b, r.op);
            e.fl  = m_flags;
            e.t   = $time;
            sb.push_back(e);
            m_out  = 1'b1;
            m_tacc = $time;
            m_last = g;
        end
        @(posedge clk);
        #1;
        if (e0) begin
            void'(q0.pop_front());
            bus.req0_valid = 1'b0;
        end
        if (e1) begin
            void'(q1.pop_front());
            bus.req1_valid = 1'b0;
        end
        if (!bus.req0_valid) begin
            if (q0.size() > 0 && !(gap_en && $urandom_range(3) == 0)) begin
                bus.req0_a = q0[0].a;
                bus.req0_b = q0[0].b;
                bus.req0_op = q0[0].op;
                bus.req0_valid = 1'b1;
            end else begin
                bus.req0_a = 16'($urandom);
                bus.req0_b = 16'($urandom);
                bus.req0_op = 4'($urandom);
            end
        end
        if (!bus.req1_valid) begin
            if (q1.size() > 0 && !(gap_en && $urandom_range(3) == 0)) begin
                bus.req1_a = q1[0].a;
                bus.req1_b = q1[0].b;
                bus.req1_op = q1[0].op;
                bus.req1_valid = 1'b1;
            end else begin
                bus.req1_a = 16'($urandom);
                bus.req1_b = 16'($urandom);
                bus.req1_op = 4'($urandom);
            end
        end
        case (rmode)
            0:       bus.rsp_ready = 1'b1;
            1:       bus.rsp_ready = 1'b0;
            default: bus.rsp_ready = 1'($urandom);
        endcase
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(int budget);
        int k;
        k = 0;
        while (q0.size() > 0 || q1.size() > 0 || sb.size() > 0 ||
               bus.req0_valid || bus.req1_valid) begin
            if (k == budget) begin
                chk("drain_timeout", 32'd1, 32'd0);
                break;
            end
            cycle();
            k++;
        end
        run(2);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_a = '0;
        bus.req0_b = '0;
        bus.req0_op = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a = '0;
        bus.req1_b = '0;
        bus.req1_op = '0;
        bus.rsp_ready = 1'b1;
        m_out = 1'b0;
        m_last = 1'b1;
        m_flags = 3'b000;
        rmode = 0;
        gap_en = 1'b0;

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("rst_flags", 32'(bus.flags_q), 32'd0);
        rst_n = 1'b1;

        // Both requesters busy: grants must alternate starting with req0.
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            push_op(1'b0, 16'(i * 3 + 1), 16'h0011, 4'd2);
            push_op(1'b1, 16'(i * 5 + 2), 16'h0101, 4'd3);
        end
        drain(100);
        chk("t2_count", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk("t2_grant", 32'(glog[i]), 32'(i % 2));

        push_op(1'b0, 16'h7FFF, 16'h0001, 4'd0);
        drain(50);
        chk("t1_flags", 32'(bus.flags_q), 32'b101);

        push_op(1'b0, 16'h1234, 16'h1234, 4'd4);
        drain(50);
        chk("t5_flags", 32'(bus.flags_q), 32'b111);

        push_op(1'b0, 16'h0005, 16'h0005, 4'd1);
        drain(50);
        chk("t3_sub_flags", 32'(bus.flags_q), 32'b010);
        push_op(1'b0, 16'h1200, 16'h0034, 4'd10);
        drain(50);
        chk("t3_llb_flags", 32'(bus.flags_q), 32'b010);

        // Consumer stalls in RESP while req1 waits.
        rmode = 1;
        push_op(1'b0, 16'h00F0, 16'h0F00, 4'd3);
        push_op(1'b1, 16'h4000, 16'h4000, 4'd0);
        run(8);
        chk("t4_stall_ready", 32'(bus.req1_ready), 32'd0);
        chk("t4_stall_valid", 32'(bus.rsp_valid), 32'd1);
        rmode = 0;
        drain(50);
        chk("t4_flags", 32'(bus.flags_q), 32'b101);

        // Reset while the op is in EXEC.
        push_op(1'b0, 16'h8000, 16'h8000, 4'd0);
        run(2);
        chk("t6_in_flight", 32'(sb.size()), 32'd1);
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t6_flags", 32'(bus.flags_q), 32'd0);
        chk("t6_idle_ready", 32'(bus.req0_ready), 32'd1);
        bus.req0_valid = 1'b0;
        sb.delete();
        seen = 1'b0;
        m_out = 1'b0;
        m_last = 1'b1;
        m_flags = 3'b000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic with gaps and random consumer backpressure.
        rmode = 2;
        gap_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            push_op(1'b0, 16'($urandom), 16'($urandom), 4'($urandom));
            push_op(1'b1, 16'($urandom), 16'($urandom), 4'($urandom));
        end
        drain(2000);
        rmode = 0;
        run(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
